// File: rtl/fft8_input_loader.sv
// Input loader for the fft8 core: collects 8 complex samples in bit-reversed order,
// starts the core and waits for fft_done. Optional macro: FFT8_LOADER_LAST_CHECK_EN.
module fft8_input_loader #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              in_last,
  output logic              fft_start,
  input  logic              fft_done,
  input  logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] rd_re,
  output logic [DATA_W-1:0] rd_im,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_done,
  output logic              timeout_err,
  output logic              frame_err
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        wr_cnt, wr_cnt_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic              accept;
  logic              frame_bad;
  logic              done_inc;
  logic              set_timeout;
  logic              set_frame_err;
  logic [2:0]        wr_addr;

  logic [DATA_W-1:0] buf_re [8];
  logic [DATA_W-1:0] buf_im [8];

  assign in_ready  = (state == FILL) && !rst;
  assign busy      = (state != FILL);
  assign fft_start = (state == START);
  assign accept    = in_valid && in_ready;
  assign wr_addr   = {wr_cnt[0], wr_cnt[1], wr_cnt[2]};

`ifdef FFT8_LOADER_LAST_CHECK_EN
  assign frame_bad = accept && (in_last != (wr_cnt == 3'd7));
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign frame_bad      = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    wr_cnt_nx     = wr_cnt;
    wait_nx       = wait_cnt;
    done_inc      = 1'b0;
    set_timeout   = 1'b0;
    set_frame_err = 1'b0;
    unique case (state)
      FILL: begin
        if (accept) begin
          if (frame_bad) begin
            wr_cnt_nx     = '0;
            set_frame_err = 1'b1;
          end else if (wr_cnt == 3'd7) begin
            wr_cnt_nx = '0;
            state_nx  = START;
          end else begin
            wr_cnt_nx = wr_cnt + 3'd1;
          end
        end
      end
      START: begin
        state_nx = WAIT_DONE;
        wait_nx  = '0;
      end
      WAIT_DONE: begin
        // fft_done wins over a timeout landing in the same cycle
        if (fft_done) begin
          state_nx = FILL;
          done_inc = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx    = FILL;
          set_timeout = 1'b1;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_cnt      <= '0;
      wait_cnt    <= '0;
      frames_done <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nx;
      wr_cnt   <= wr_cnt_nx;
      wait_cnt <= wait_nx;
      if (done_inc)    frames_done <= frames_done + 1'b1;
      if (set_timeout) timeout_err <= 1'b1;
    end
  end

`ifdef FFT8_LOADER_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                frame_err <= 1'b0;
    else if (set_frame_err) frame_err <= 1'b1;
  end
`else
  logic unused_set_frame_err;
  assign unused_set_frame_err = set_frame_err;
  assign frame_err            = 1'b0;
`endif

  // Buffer has no reset; a same-address write and read returns the old word.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_re[wr_addr] <= in_re;
      buf_im[wr_addr] <= in_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_re <= '0;
      rd_im <= '0;
    end else begin
      rd_re <= buf_re[rd_addr];
      rd_im <= buf_im[rd_addr];
    end
  end

endmodule
